// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit placed between the
// register file read ports and its write port. One operation is accepted
// while idle, computed over a fixed 32 iteration cycles, sign-fixed in one
// cycle, then written back with a single-cycle strobe.
//
// Ports:
//   i_clk         clock, all state changes on rising edge
//   i_rst         synchronous active-high reset (aborts any operation)
//   i_valid       issue request, operands valid this cycle
//   o_ready       unit idle and able to accept
//   i_funct3      M-extension operation select
//   i_rs1_val     operand A
//   i_rs2_val     operand B
//   i_rd          destination register select
//   o_write_en    register file write strobe (suppressed for rd = 0)
//   o_sel_write   register file write select (zero outside write cycle)
//   o_write_data  register file write data (zero outside write cycle)
//   o_done        one-cycle completion pulse
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_val,
   input  logic [XLEN-1:0] i_rs2_val,
   input  logic [4:0]      i_rd,
   output logic            o_write_en,
   output logic [4:0]      o_sel_write,
   output logic [XLEN-1:0] o_write_data,
   output logic            o_done
);

   localparam int unsigned CntW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] One    = {{(XLEN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

   state_t              state_q;
   logic [2:0]          funct3_q;
   logic [4:0]          rd_q;
   logic [XLEN-1:0]     a_mag_q;
   logic [XLEN-1:0]     b_mag_q;    // multiplier shifts right during a multiply
   logic [XLEN-1:0]     a_raw_q;    // kept for REM by zero
   logic                b_neg_q;
   logic                res_neg_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [CntW-1:0]     cnt_q;

   // Accept-side operand conditioning
   logic            a_signed, b_signed, a_neg_in, b_neg_in, res_neg_in;
   logic [XLEN-1:0] a_mag_in, b_mag_in;

   always_comb begin
      a_signed   = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                   (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
      b_signed   = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                   (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
      a_neg_in   = a_signed & i_rs1_val[XLEN-1];
      b_neg_in   = b_signed & i_rs2_val[XLEN-1];
      a_mag_in   = a_neg_in ? (~i_rs1_val + One) : i_rs1_val;
      b_mag_in   = b_neg_in ? (~i_rs2_val + One) : i_rs2_val;
      // Remainder takes the dividend's sign; product and quotient take the xor
      res_neg_in = (i_funct3[2] & i_funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
   end

   // Iteration datapath
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_diff;
   logic            div_ge;
   logic [XLEN-1:0] div_rem;

   always_comb begin
      // Shift-add: add into the high half, then shift the whole product right
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_mag_q[0] ? a_mag_q : '0)};
      // Restoring step: high half is the partial remainder, low half holds the
      // remaining dividend bits with quotient bits shifting in from the bottom
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_mag_q};
      div_ge    = ~div_diff[XLEN];
      div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
   end

   // Sign fix and result selection
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot, rem, fix_result;
   logic              div_by_zero, div_ovf;

   always_comb begin
      prod        = res_neg_q ? (~acc_q + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_q;
      quot        = res_neg_q ? (~acc_q[XLEN-1:0] + One) : acc_q[XLEN-1:0];
      rem         = res_neg_q ? (~acc_q[2*XLEN-1:XLEN] + One) : acc_q[2*XLEN-1:XLEN];
      div_by_zero = funct3_q[2] && (b_mag_q == '0);
      div_ovf     = funct3_q[2] && !funct3_q[0] && (a_raw_q == MinInt) &&
                    b_neg_q && (b_mag_q == One);
      case (funct3_q)
         3'b000:                 fix_result = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_result = quot;
         default:                fix_result = rem;
      endcase
      if (div_by_zero) begin
         fix_result = funct3_q[1] ? a_raw_q : '1;
      end else if (div_ovf) begin
         fix_result = funct3_q[1] ? '0 : MinInt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= StIdle;
         funct3_q     <= '0;
         rd_q         <= '0;
         a_mag_q      <= '0;
         b_mag_q      <= '0;
         a_raw_q      <= '0;
         b_neg_q      <= 1'b0;
         res_neg_q    <= 1'b0;
         acc_q        <= '0;
         cnt_q        <= '0;
         o_ready      <= 1'b1;
         o_write_en   <= 1'b0;
         o_done       <= 1'b0;
         o_sel_write  <= '0;
         o_write_data <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_valid) begin
                  funct3_q  <= i_funct3;
                  rd_q      <= i_rd;
                  a_mag_q   <= a_mag_in;
                  b_mag_q   <= b_mag_in;
                  a_raw_q   <= i_rs1_val;
                  b_neg_q   <= b_neg_in;
                  res_neg_q <= res_neg_in;
                  // Divide seeds the low half with the dividend magnitude
                  acc_q     <= i_funct3[2] ? {{XLEN{1'b0}}, a_mag_in} : '0;
                  cnt_q     <= '0;
                  o_ready   <= 1'b0;
                  state_q   <= StCalc;
               end
            end
            StCalc: begin
               cnt_q <= cnt_q + 1'b1;
               if (funct3_q[2]) begin
                  acc_q <= {div_rem, acc_q[XLEN-2:0], div_ge};
               end else begin
                  acc_q   <= {mul_sum, acc_q[XLEN-1:1]};
                  b_mag_q <= b_mag_q >> 1;
               end
               if (cnt_q == CntW'(XLEN - 1)) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               o_done       <= 1'b1;
               o_write_en   <= (rd_q != 5'd0);
               o_sel_write  <= rd_q;
               o_write_data <= fix_result;
               state_q      <= StDone;
            end
            StDone: begin
               o_done       <= 1'b0;
               o_write_en   <= 1'b0;
               o_sel_write  <= '0;
               o_write_data <= '0;
               o_ready      <= 1'b1;
               state_q      <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        ready;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd;
   logic        we;
   logic [4:0]  sel;
   logic [31:0] wdata;
   logic        done;

   int vectors = 0;
   int miscompares = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_funct3    (funct3),
      .i_rs1_val   (rs1),
      .i_rs2_val   (rs2),
      .i_rd        (rd),
      .o_write_en  (we),
      .o_sel_write (sel),
      .o_write_data(wdata),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op at cycle 0 and follow it through cycle 40.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst, input logic [31:0] exp, input string tag,
                         input bit pulse_busy);
      int done_cnt;
      bit busy_bad;
      bit early_bad;
      done_cnt  = 0;
      busy_bad  = 1'b0;
      early_bad = 1'b0;
      @(posedge clk); #1;
      valid  = 1'b1;
      funct3 = f3;
      rs1    = a;
      rs2    = b;
      rd     = dst;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c <= 34 && ready !== 1'b0) busy_bad = 1'b1;
         if (done === 1'b1) done_cnt++;
         if (c != 34 && (we !== 1'b0 || done !== 1'b0)) early_bad = 1'b1;
         if (c == 34) begin
            check({tag, " done"}, {31'd0, done}, 32'd1);
            check({tag, " we"}, {31'd0, we}, {31'd0, (dst != 5'd0)});
            check({tag, " sel"}, {27'd0, sel}, {27'd0, dst});
            check({tag, " data"}, wdata, exp);
         end
         if (c == 35) begin
            check({tag, " ready after"}, {31'd0, ready}, 32'd1);
            check({tag, " data cleared"}, wdata, 32'd0);
            check({tag, " sel cleared"}, {27'd0, sel}, 32'd0);
         end
         // Requests while busy must be dropped
         valid = pulse_busy && c >= 5 && c <= 20;
         if (valid) begin
            funct3 = 3'b100;
            rs1    = 32'd1000 + c;
            rs2    = 32'd3;
            rd     = 5'd9;
         end
      end
      valid = 1'b0;
      check({tag, " busy ready low"}, {31'd0, busy_bad}, 32'd0);
      check({tag, " no stray strobe"}, {31'd0, early_bad}, 32'd0);
      check({tag, " done count"}, done_cnt, 32'd1);
   endtask

   initial begin
      bit stray;
      rst    = 1'b1;
      valid  = 1'b0;
      funct3 = '0;
      rs1    = '0;
      rs2    = '0;
      rd     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ready", {31'd0, ready}, 32'd1);
      check("reset we", {31'd0, we}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset sel", {27'd0, sel}, 32'd0);
      check("reset data", wdata, 32'd0);
      rst = 1'b0;

      run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "mul 7x-3", 1'b0);
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, "mulh", 1'b0);
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, "mulhsu", 1'b0);
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, "mulhu", 1'b0);
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, "mulh minint", 1'b0);
      run_op(3'b011, 32'h8000_0000, 32'h0000_0002, 5'd11, 32'h0000_0001, "mulhu carry", 1'b0);
      run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFD, "div -7/2", 1'b0);
      run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd13, 32'hFFFF_FFFF, "rem -7/2", 1'b0);
      run_op(3'b101, 32'd100, 32'd7, 5'd14, 32'd14, "divu 100/7", 1'b0);
      run_op(3'b111, 32'd100, 32'd7, 5'd15, 32'd2, "remu 100/7", 1'b0);
      run_op(3'b100, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, "div 5/0", 1'b0);
      run_op(3'b111, 32'd5, 32'd0, 5'd17, 32'd5, "remu 5/0", 1'b0);
      run_op(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd18, 32'hFFFF_FFFB, "rem -5/0", 1'b0);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, "div ovf", 1'b0);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000, "rem ovf", 1'b0);
      run_op(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, "mul rd0 busy", 1'b1);

      // Abort a divide with reset during cycle 15
      @(posedge clk); #1;
      valid  = 1'b1;
      funct3 = 3'b100;
      rs1    = 32'd1234;
      rs2    = 32'd5;
      rd     = 5'd3;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         valid = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort ready", {31'd0, ready}, 32'd1);
      stray = 1'b0;
      for (int c = 17; c <= 40; c++) begin
         if (we !== 1'b0 || done !== 1'b0) stray = 1'b1;
         @(posedge clk); #1;
      end
      check("abort no write", {31'd0, stray}, 32'd0);
      run_op(3'b000, 32'd2, 32'd3, 5'd4, 32'd6, "mul after abort", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
